// File: rtl/pll_phase_sweep_pkg.sv
// Shared types for the PLL phase sweep: FSM state encoding and phasedir values.
package pll_phase_sweep_pkg;

  typedef enum logic [3:0] {
    IDLE, PRE, PULSE, SETTLE, BASE, DWELL, EVAL, SCAN, CENTER, DONE
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/pll_phase_sweep_run_scan.sv
// Longest circular run of 1s in a STEPS-bit map; ties go to the lowest start index.
// Walks the map twice (2*STEPS cycles) so runs that wrap past STEPS-1 are seen whole.
module run_scan #(
  parameter int STEPS = 32,
  localparam int PW = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [STEPS-1:0] bits,
  output logic             done,
  output logic [PW-1:0]    lo,
  output logic [PW:0]      len
);

  localparam logic [PW:0] FULL = (PW+1)'(STEPS);
  localparam logic [PW:0] LAST = (PW+1)'(2*STEPS-1);

  logic          active;
  logic [PW:0]   i, cur, cur_n;
  logic [PW-1:0] cur_lo, run_lo, idx;

  assign idx = i[PW-1:0];

  // Run length saturates at STEPS so an all-ones map reports lo=0, len=STEPS.
  always_comb begin
    cur_n  = (cur == FULL) ? cur : cur + 1'b1;
    run_lo = (cur == '0) ? idx : cur_lo;
  end

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      active <= 1'b0;
      i      <= '0;
      cur    <= '0;
      cur_lo <= '0;
      lo     <= '0;
      len    <= '0;
    end else if (start) begin
      active <= 1'b1;
      i      <= '0;
      cur    <= '0;
      lo     <= '0;
      len    <= '0;
    end else if (active) begin
      if (bits[idx]) begin
        cur    <= cur_n;
        cur_lo <= run_lo;
        // Strictly greater: the first run to reach a length keeps it.
        if (cur_n > len) begin
          len <= cur_n;
          lo  <= run_lo;
        end
      end else begin
        cur <= '0;
      end
      i <= i + 1'b1;
      if (i == LAST) begin
        active <= 1'b0;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_phase_sweep.sv
// PLL phase sweep: tests every phase step against a memory tester, centres on the widest
// passing window. Optional debounced manual inc/dec stepping with PLL_PHASE_SWEEP_MANUAL_EN.
module pll_phase_sweep
  import pll_phase_sweep_pkg::*;
#(
  parameter int STEPS         = 32,
  parameter int DWELL_CYCLES  = 50000000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int PULSE_CYCLES  = 4,
  parameter int DEBOUNCE_BITS = 16,
  localparam int PW = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inc,
  input  logic          dec,
  input  logic [31:0]   failcount,
  output logic          phasedir,
  output logic          phasestep,
  output logic          phaseloadreg,
  output logic [PW-1:0] phase,
  output logic [PW-1:0] win_lo,
  output logic [PW-1:0] win_hi,
  output logic          busy,
  output logic          done,
  output logic          no_window
);

  localparam logic [PW:0] FULL = (PW+1)'(STEPS);

  state_t           state, state_n;
  logic [31:0]      cnt, base;
  logic             cnt_done;
  logic [STEPS-1:0] bitmap;
  logic [PW:0]      k, len;
  logic [PW-1:0]    remain, lo, hi_n, target;
  logic             dir, centering, scan_start, scan_done, man_up, man_dn;

  run_scan #(.STEPS(STEPS)) u_scan (
    .clk  (clk),
    .rst  (rst),
    .start(scan_start),
    .bits (bitmap),
    .done (scan_done),
    .lo   (lo),
    .len  (len)
  );

  assign hi_n   = lo + len[PW-1:0] - 1'b1;
  assign target = lo + len[PW:1];

`ifdef PLL_PHASE_SWEEP_MANUAL_EN
  logic [1:0] raw, db, flip, arm;
  logic [1:0][DEBOUNCE_BITS-1:0] dcnt;
  logic chord;

  assign raw  = {dec, inc};
  assign flip = (raw ^ db) & {&dcnt[1], &dcnt[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      db    <= '0;
      dcnt  <= '0;
      arm   <= '0;
      chord <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (raw[b] == db[b] || flip[b]) dcnt[b] <= '0;
        else                            dcnt[b] <= dcnt[b] + 1'b1;
        if (flip[b]) begin
          db[b]  <= raw[b];
          // A press only counts if it began while no sweep was running.
          arm[b] <= raw[b] & ~busy;
        end
      end
      if (&db)            chord <= 1'b1;
      else if (db == '0)  chord <= 1'b0;
    end
  end

  assign man_up = flip[0] & db[0] & arm[0] & ~chord & ~db[1];
  assign man_dn = flip[1] & db[1] & arm[1] & ~chord & ~db[0];
`else
  localparam int unused_db = DEBOUNCE_BITS;
  logic unused_btn;
  assign unused_btn = inc ^ dec;
  assign man_up = 1'b0;
  assign man_dn = 1'b0;
`endif

  always_comb begin
    cnt_done = 1'b0;
    case (state)
      PULSE:   cnt_done = (cnt == 32'(PULSE_CYCLES - 1));
      SETTLE:  cnt_done = (cnt == 32'(SETTLE_CYCLES - 1));
      DWELL:   cnt_done = (cnt == 32'(DWELL_CYCLES - 1));
      default: cnt_done = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    scan_start = 1'b0;
    case (state)
      IDLE:   if (start) state_n = SETTLE;
              else if (man_up || man_dn) state_n = PRE;
      PRE:    state_n = PULSE;
      PULSE:  if (cnt_done) begin
                if (!busy)          state_n = IDLE;
                else if (centering) state_n = CENTER;
                else if (k == FULL) begin
                  state_n    = SCAN;
                  scan_start = 1'b1;
                end else            state_n = SETTLE;
              end
      SETTLE: if (cnt_done) state_n = BASE;
      BASE:   state_n = DWELL;
      DWELL:  if (cnt_done) state_n = EVAL;
      EVAL:   state_n = PRE;
      SCAN:   if (scan_done) state_n = (len == '0) ? DONE : CENTER;
      CENTER: state_n = (remain == '0) ? DONE : PRE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      bitmap    <= '0;
      k         <= '0;
      remain    <= '0;
      dir       <= DIR_UP;
      centering <= 1'b0;
      phase     <= '0;
      win_lo    <= '0;
      win_hi    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      no_window <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
                bitmap    <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                no_window <= 1'b0;
                k         <= '0;
                centering <= 1'b0;
              end else if (man_up) dir <= DIR_UP;
              else if (man_dn)     dir <= DIR_DN;
        PULSE: if (cnt_done) phase <= (dir == DIR_DN) ? phase - 1'b1 : phase + 1'b1;
        BASE:  base <= failcount;
        EVAL: begin
          // Any change at all, wrap included, marks the phase as failing.
          bitmap[phase] <= (failcount == base);
          k             <= k + 1'b1;
          dir           <= DIR_UP;
        end
        SCAN: if (scan_done) begin
                if (len == '0) begin
                  no_window <= 1'b1;
                  win_lo    <= '0;
                  win_hi    <= '0;
                end else begin
                  win_lo    <= lo;
                  win_hi    <= hi_n;
                  remain    <= target - phase;
                  centering <= 1'b1;
                end
              end
        CENTER: if (remain != '0) begin
                  remain <= remain - 1'b1;
                  dir    <= DIR_UP;
                end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign phasestep    = (state == PULSE);
  assign phasedir     = (state == PRE || state == PULSE) & dir;
  assign phaseloadreg = 1'b0;

endmodule

// File: tb/tb_pll_phase_sweep.sv
// Scoreboard bench for pll_phase_sweep: a fail-mask tester model drives failcount, a reference
// model predicts window/phase/pulse count per sweep, and a monitor checks each completion.
module tb_pll_phase_sweep;
  localparam int STEPS = 8;
  localparam int PW    = 3;
`ifdef PLL_PHASE_SWEEP_MANUAL_EN
  localparam int MAN = 1;
`else
  localparam int MAN = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, inc, dec;
  logic [31:0] failcount;
  logic [31:0] fc_base = '0;
  logic [31:0] fc_acc  = '0;
  logic phasedir, phasestep, phaseloadreg, busy, done, no_window;
  logic [PW-1:0] phase, win_lo, win_hi;
  logic [STEPS-1:0] fail_mask = '0;

  typedef struct {int lo; int hi; int ph; int nw; int np;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;
  int cur_ph = 0, npulse = 0, ps_total = 0, last_dir = 0;
  logic prev_ps = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;

  pll_phase_sweep #(
    .STEPS(8), .DWELL_CYCLES(16), .SETTLE_CYCLES(4), .PULSE_CYCLES(2), .DEBOUNCE_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .inc(inc), .dec(dec), .failcount(failcount),
    .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg), .phase(phase),
    .win_lo(win_lo), .win_hi(win_hi), .busy(busy), .done(done), .no_window(no_window)
  );

  always #5 clk = ~clk;

  // Memory tester: errors accumulate every cycle the PLL sits on a failing phase.
  assign failcount = fc_base + fc_acc;
  always @(posedge clk) if (fail_mask[phase]) fc_acc <= fc_acc + 32'd1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy && !prev_busy) npulse = 0;
    if (phasestep && prev_ps) chk("dir_stable", int'(phasedir), last_dir);
    if (phasestep && !prev_ps) begin
      npulse++;
      ps_total++;
      last_dir = int'(phasedir);
    end
    if (done && !prev_done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("win_lo", int'(win_lo), e.lo);
        chk("win_hi", int'(win_hi), e.hi);
        chk("phase", int'(phase), e.ph);
        chk("no_window", int'(no_window), e.nw);
        chk("pulses", npulse, e.np);
        chk("busy_at_done", int'(busy), 0);
        chk("phaseloadreg", int'(phaseloadreg), 0);
      end
    end
    prev_ps   = phasestep;
    prev_busy = busy;
    prev_done = done;
  end

  // Reference: enumerate maximal circular runs of passing phases, keep the longest,
  // lowest start on ties.
  function automatic exp_t model(input logic [7:0] fm, input int p0);
    exp_t r;
    int bl = 0, bs = 0, len;
    logic [7:0] ps;
    ps = ~fm;
    if (ps == 8'hFF) begin
      bl = 8;
      bs = 0;
    end else begin
      for (int s = 0; s < 8; s++)
        if (ps[s] && !ps[(s + 7) % 8]) begin
          len = 0;
          while (ps[(s + len) % 8]) len++;
          if (len > bl) begin
            bl = len;
            bs = s;
          end
        end
    end
    if (bl == 0) r = '{0, 0, p0, 1, 8};
    else begin
      r.lo = bs;
      r.hi = (bs + bl - 1) % 8;
      r.ph = (bs + bl / 2) % 8;
      r.nw = 0;
      r.np = 8 + (r.ph - p0 + 8) % 8;
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(done && !busy) && t < 3000) begin
      tick(1);
      t++;
    end
    if (t >= 3000) chk("done_timeout", 0, 1);
    tick(2);
  endtask

  task automatic push(input logic [7:0] fm);
    exp_t r;
    r = model(fm, cur_ph);
    sb.push_back(r);
    cur_ph = r.ph;
  endtask

  task automatic run(input logic [7:0] fm, input logic [31:0] fb);
    fail_mask = fm;
    fc_base   = fb;
    push(fm);
    pulse_start();
    wait_done();
  endtask

  task automatic press(input logic a, input logic b);
    inc = a;
    dec = b;
    tick(20);
    inc = 1'b0;
    dec = 1'b0;
    tick(20);
  endtask

  initial begin
    int b, t;
    rst = 1'b1; start = 1'b0; inc = 1'b0; dec = 1'b0;
    tick(3);
    chk("rst_outputs", int'({phasedir, phasestep, phaseloadreg, busy, done, no_window}), 0);
    chk("rst_phase_win", int'({phase, win_lo, win_hi}), 0);
    rst = 1'b0;
    tick(2);

    // Manual stepping (acts only when the manual feature is built in).
    b = ps_total;
    press(1'b1, 1'b0);
    chk("man_inc_phase", int'(phase), (cur_ph + MAN) % 8);
    chk("man_inc_pulses", ps_total - b, MAN);
`ifdef PLL_PHASE_SWEEP_MANUAL_EN
    chk("man_inc_dir", last_dir, 0);
`endif
    cur_ph = (cur_ph + MAN) % 8;
    b = ps_total;
    press(1'b0, 1'b1);
    chk("man_dec_phase", int'(phase), (cur_ph + 8 - MAN) % 8);
`ifdef PLL_PHASE_SWEEP_MANUAL_EN
    chk("man_dec_dir", last_dir, 1);
`endif
    cur_ph = (cur_ph + 8 - MAN) % 8;
    b = ps_total;
    press(1'b1, 1'b1);
    chk("man_chord_pulses", ps_total - b, 0);
    chk("man_chord_phase", int'(phase), cur_ph);

    // Directed sweeps from the worked examples.
    run(8'h83, 32'd100);
    chk("ex1_win_lo", int'(win_lo), 2);
    chk("ex1_win_hi", int'(win_hi), 6);
    chk("ex1_phase", int'(phase), 4);
    chk("ex1_pulses", npulse, 12);
    run(8'h3C, 32'd7);
    chk("ex2_win_lo", int'(win_lo), 6);
    chk("ex2_win_hi", int'(win_hi), 1);
    chk("ex2_phase", int'(phase), 0);
    run(8'hFF, 32'd0);
    chk("allfail_nowin", int'(no_window), 1);
    chk("allfail_phase", int'(phase), 0);
    chk("allfail_pulses", npulse, 8);
    run(8'h00, 32'd55);
    chk("allpass_win", int'({win_lo, win_hi}), 7);
    chk("allpass_phase", int'(phase), 4);
    // Tester counter wraps through zero on a failing phase.
    run(8'h10, 32'hFFFF_FFF8);

    // start while busy is ignored.
    fail_mask = 8'h21;
    push(8'h21);
    pulse_start();
    tick(40);
    pulse_start();
    wait_done();

    for (int i = 0; i < 6; i++) run(8'($urandom), $urandom);

    // Reset in the third dwell.
    fail_mask = 8'h03;
    b = ps_total;
    pulse_start();
    t = 0;
    while (!(ps_total >= b + 2 && !phasestep) && t < 2000) begin
      tick(1);
      t++;
    end
    if (t >= 2000) chk("dwell_timeout", 0, 1);
    tick(10);
    rst = 1'b1;
    tick(1);
    chk("midrst_outputs", int'({phasedir, phasestep, phaseloadreg, busy, done, no_window}), 0);
    chk("midrst_phase_win", int'({phase, win_lo, win_hi}), 0);
    rst = 1'b0;
    cur_ph = 0;
    tick(2);
    run(8'h83, 32'd9);
    chk("post_rst_phase", int'(phase), 4);

    // Button activity during a sweep must not step afterwards.
    fail_mask = 8'h0E;
    push(8'h0E);
    pulse_start();
    tick(20);
    press(1'b1, 1'b0);
    wait_done();
    tick(30);
    chk("busy_press_phase", int'(phase), cur_ph);

    tick(5);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
